// File: rtl/spram_arb_pkg.sv
// Shared types for the two-port single-port-RAM arbiter: response slot states,
// port count and port index type.
package spram_arb_pkg;

   localparam int NumPorts = 2;

   typedef enum logic [1:0] {
      SLOT_IDLE = 2'd0,
      SLOT_WAIT = 2'd1,
      SLOT_HOLD = 2'd2
   } slot_state_e;

   typedef logic [0:0] port_idx_t;

   function automatic port_idx_t other_port(input port_idx_t p);
      return ~p;
   endfunction

endpackage

// File: rtl/spram_arb_rsp_slot.sv
// Per-port response slot: tracks an outstanding read and keeps its data in a hold
// register until the consumer accepts it.
module spram_arb_rsp_slot
   import spram_arb_pkg::*;
#(
   parameter int DataBusWidth = 32
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    rd_grant,
   input  logic                    rsp_ready,
   input  logic [DataBusWidth-1:0] mem_rdata,
   output logic                    rsp_valid,
   output logic [DataBusWidth-1:0] rsp_data,
   output logic                    eligible,
   output logic [1:0]              state_dbg
);

   slot_state_e             state_q;
   slot_state_e             state_d;
   logic [DataBusWidth-1:0] hold_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= SLOT_IDLE;
         hold_q  <= '0;
      end else begin
         state_q <= state_d;
         // RAM data is only valid in the WAIT cycle; capture it so HOLD stays stable.
         if (state_q == SLOT_WAIT) begin
            hold_q <= mem_rdata;
         end
      end
   end

   always_comb begin
      state_d   = state_q;
      rsp_valid = 1'b0;
      rsp_data  = hold_q;
      eligible  = 1'b0;
      case (state_q)
         SLOT_IDLE: begin
            eligible = 1'b1;
            if (rd_grant) begin
               state_d = SLOT_WAIT;
            end
         end
         SLOT_WAIT: begin
            rsp_valid = 1'b1;
            rsp_data  = mem_rdata;
            eligible  = rsp_ready;
            if (rsp_ready) begin
               state_d = rd_grant ? SLOT_WAIT : SLOT_IDLE;
            end else begin
               state_d = SLOT_HOLD;
            end
         end
         SLOT_HOLD: begin
            rsp_valid = 1'b1;
            rsp_data  = hold_q;
            eligible  = rsp_ready;
            if (rsp_ready) begin
               state_d = rd_grant ? SLOT_WAIT : SLOT_IDLE;
            end
         end
         default: begin
            state_d = SLOT_IDLE;
         end
      endcase
   end

   assign state_dbg = state_q;

endmodule

// File: rtl/spram_arbiter.sv
// Round-robin arbiter sharing one single-port RAM (1-cycle read latency) between
// two requesters, with a per-port response slot so read data is never lost.
module spram_arbiter
   import spram_arb_pkg::*;
#(
   parameter int AddrBusWidth = 32,
   parameter int DataBusWidth = 32
) (
   input  logic                                   clk,
   input  logic                                   rst,
   // Handshakes: a request transfers in a cycle where req_valid & req_ready are both 1;
   // a response is consumed in a cycle where rsp_valid & rsp_ready are both 1.
   // req_ready may depend combinationally on rsp_ready of the same port.
   input  logic [NumPorts-1:0]                    req_valid,
   output logic [NumPorts-1:0]                    req_ready,
   input  logic [NumPorts-1:0]                    req_we,
   input  logic [NumPorts-1:0][AddrBusWidth-1:0]  req_addr,
   input  logic [NumPorts-1:0][DataBusWidth-1:0]  req_wdata,
   output logic [NumPorts-1:0]                    rsp_valid,
   input  logic [NumPorts-1:0]                    rsp_ready,
   output logic [NumPorts-1:0][DataBusWidth-1:0]  rsp_data,
   output logic                                   mem_re,
   output logic                                   mem_we,
   output logic [AddrBusWidth-1:0]                mem_addr,
   output logic [DataBusWidth-1:0]                mem_wdata,
   input  logic [DataBusWidth-1:0]                mem_rdata,
   output logic [NumPorts-1:0][1:0]               dbg_slot_state
);

   port_idx_t           rr_q;
   port_idx_t           winner;
   logic [NumPorts-1:0] slot_elig;
   logic [NumPorts-1:0] req_elig;
   logic [NumPorts-1:0] grant;
   logic [NumPorts-1:0] rd_grant;

   // Writes need no response slot, so they are eligible regardless of slot state.
   assign req_elig = req_valid & (req_we | slot_elig);

   always_comb begin
      grant  = '0;
      winner = port_idx_t'(0);
      if (!rst) begin
         if (req_elig[0] && req_elig[1]) begin
            winner = rr_q;
         end else if (req_elig[1]) begin
            winner = port_idx_t'(1);
         end else begin
            winner = port_idx_t'(0);
         end
         grant[winner] = req_elig[winner];
      end
   end

   assign req_ready = grant;
   assign rd_grant  = grant & ~req_we;

   always_comb begin
      mem_addr  = req_addr[winner];
      mem_wdata = req_wdata[winner];
      mem_re    = |grant & ~req_we[winner];
      mem_we    = |grant &  req_we[winner];
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         rr_q <= port_idx_t'(0);
      end else if (|grant) begin
         rr_q <= other_port(winner);
      end
   end

   for (genvar p = 0; p < NumPorts; p++) begin : g_slot
      spram_arb_rsp_slot #(
         .DataBusWidth (DataBusWidth)
      ) u_slot (
         .clk       (clk),
         .rst       (rst),
         .rd_grant  (rd_grant[p]),
         .rsp_ready (rsp_ready[p]),
         .mem_rdata (mem_rdata),
         .rsp_valid (rsp_valid[p]),
         .rsp_data  (rsp_data[p]),
         .eligible  (slot_elig[p]),
         .state_dbg (dbg_slot_state[p])
      );
   end

endmodule
